// File: rtl/mem_stream_loader_pkg.sv
// mem_stream_loader_pkg: FSM state encoding and transfer mode constants for the stream loader
package mem_stream_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DUMP, DONE} state_t;
  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_DUMP = 1'b1;
endpackage

// File: rtl/mem_stream_loader_if.sv
// mem_stream_loader_if: control, stream and memory-port bundle between the loader and its environment
interface mem_stream_loader_if #(parameter int AW = 32, parameter int DW = 32, parameter int LENW = 16);
  logic            start;
  logic            mode;
  logic [AW-1:0]   base_addr;
  logic [LENW-1:0] length;
  logic            s_valid;
  logic [DW-1:0]   s_data;
  logic            s_ready;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic            m_ready;
  logic [AW-1:0]   mem_r_addr;
  logic [DW-1:0]   mem_dout;
  logic [AW-1:0]   mem_w_addr;
  logic            mem_w_en;
  logic [DW-1:0]   mem_din;
  logic            busy;
  logic            done;
  logic [DW-1:0]   checksum;
  modport master (
    input  start, mode, base_addr, length, s_valid, s_data, m_ready, mem_dout,
    output s_ready, m_valid, m_data, mem_r_addr, mem_w_addr, mem_w_en, mem_din, busy, done, checksum
  );
  modport slave (
    output start, mode, base_addr, length, s_valid, s_data, m_ready, mem_dout,
    input  s_ready, m_valid, m_data, mem_r_addr, mem_w_addr, mem_w_en, mem_din, busy, done, checksum
  );
endinterface

// File: rtl/mem_stream_loader_addr_gen.sv
// mem_addr_gen: latches base/length, counts the word index and decodes address, last and more
module mem_addr_gen #(parameter int AW = 32, parameter int LENW = 16) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic            inc,
  input  logic [AW-1:0]   base_in,
  input  logic [LENW-1:0] len_in,
  output logic [AW-1:0]   addr,
  output logic            last,
  output logic            more
);
  logic [AW-1:0]   base_q;
  logic [LENW-1:0] len_q;
  logic [LENW-1:0] idx;
  always_ff @(posedge clk)
    if (rst) begin
      base_q <= '0;
      len_q  <= '0;
      idx    <= '0;
    end else begin
      if (ld) begin
        base_q <= base_in;
        len_q  <= len_in;
      end
      idx <= (ld ? '0 : idx) + LENW'(inc);
    end
  // the start cycle already points at base_in so a dump can fetch its first word immediately
  assign addr = ld ? base_in : base_q + AW'(idx);
  assign last = idx == len_q - LENW'(1);
  assign more = idx != len_q;
endmodule

// File: rtl/mem_stream_loader.sv
// mem_stream_loader: streams words into (LOAD) or out of (DUMP) a comb-read/sync-write word memory.
// Define MEM_STREAM_LOADER_CHECKSUM_EN to enable the running word-sum output.
module mem_stream_loader
  import mem_stream_loader_pkg::*;
#(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int LENW = 16
) (
  input logic clk,
  input logic rst,
  mem_stream_loader_if.master bus
);
  state_t        state;
  logic [AW-1:0] addr;
  logic          last, more, ld, inc, beat, load, acc, start_dump;
  assign ld         = state == IDLE && bus.start;
  assign start_dump = ld && bus.mode == MODE_DUMP && bus.length != '0;
  assign beat       = state == LOAD && bus.s_valid && bus.s_ready;
  assign load       = state == DUMP && (!bus.m_valid || bus.m_ready) && more;
  assign acc        = bus.m_valid && bus.m_ready;
  assign inc        = beat || load || start_dump;
  assign bus.mem_r_addr = addr;
  mem_addr_gen #(.AW(AW), .LENW(LENW)) u_addr (
    .clk, .rst, .ld, .inc,
    .base_in(bus.base_addr),
    .len_in(bus.length),
    .addr, .last, .more
  );
  always_ff @(posedge clk)
    if (rst) begin
      state          <= IDLE;
      bus.s_ready    <= 1'b0;
      bus.m_valid    <= 1'b0;
      bus.m_data     <= '0;
      bus.mem_w_addr <= '0;
      bus.mem_w_en   <= 1'b0;
      bus.mem_din    <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.mem_w_en <= beat;
      bus.done     <= 1'b0;
      if (beat) begin
        bus.mem_w_addr <= addr;
        bus.mem_din    <= bus.s_data;
      end
      if (load || start_dump) begin
        bus.m_data  <= bus.mem_dout;
        bus.m_valid <= 1'b1;
      end else if (acc) bus.m_valid <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bus.busy    <= 1'b1;
          bus.s_ready <= bus.length != '0 && bus.mode == MODE_LOAD;
          state       <= bus.length == '0 ? DONE : bus.mode == MODE_DUMP ? DUMP : LOAD;
        end
        LOAD: if (beat && last) begin
          bus.s_ready <= 1'b0;
          state       <= DONE;
        end
        DUMP: if (acc && !more) state <= DONE;
        DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef MEM_STREAM_LOADER_CHECKSUM_EN
  logic [DW-1:0] sum;
  always_ff @(posedge clk)
    if (rst || ld) sum <= '0;
    else if (beat) sum <= sum + bus.s_data;
    else if (acc) sum <= sum + bus.m_data;
  assign bus.checksum = sum;
`else
  assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_mem_stream_loader.sv
// tb_mem_stream_loader: scoreboard bench with a comb-read/sync-write word memory model
module tb_mem_stream_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stream_loader_if #(.AW(32), .DW(32), .LENW(16)) bif ();
  mem_stream_loader dut (.clk(clk), .rst(rst), .bus(bif));

  logic [31:0] mem [0:65535];
  logic        pre_en;
  logic [15:0] pre_a;
  logic [31:0] pre_d;
  assign bif.mem_dout = mem[bif.mem_r_addr[15:0]];
  always @(posedge clk)
    if (bif.mem_w_en) mem[bif.mem_w_addr[15:0]] <= bif.mem_din;
    else if (pre_en) mem[pre_a] <= pre_d;

  int tests = 0;
  int fails = 0;
  logic [31:0] words [0:9] = '{32'd431, 32'd413, 32'd143, 32'd134, 32'd314,
                               32'd341, 32'd0, 32'd4, 32'd3, 32'd1};
  logic [31:0] src [0:15];
  logic [63:0] exp_q [$];
  logic [31:0] dq [$];
  logic [31:0] exp_ck;

  initial begin
`ifdef MEM_STREAM_LOADER_CHECKSUM_EN
    exp_ck = 32'd1784;
`else
    exp_ck = 32'd0;
`endif
  end

  task automatic do_load(input logic [31:0] base, input int len, input bit gaps, input int rst_after,
                         output int nbeats, output int ndone);
    int k = 0;
    bit pend = 1'b0;
    bit fin = 1'b0;
    logic [63:0] e;
    exp_q.delete();
    ndone = 0;
    bif.mode = 1'b0; bif.base_addr = base; bif.length = 16'(len); bif.start = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    tests++;
    if (bif.s_ready !== 1'b1 || bif.busy !== 1'b1) begin
      fails++; $display("FAIL load_start s_ready=%b busy=%b required 1 1", bif.s_ready, bif.busy);
    end
    bif.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    bif.s_data = src[0];
    for (int c = 0; c < 200 && !fin; c++) begin
      pend = bif.s_valid && bif.s_ready;
      if (pend) begin exp_q.push_back({base + 32'(k), src[k]}); k++; end
      @(posedge clk); #1;
      tests++;
      if (bif.mem_w_en !== pend) begin
        fails++; $display("FAIL load_wen cycle %0d: mem_w_en=%b required %b", c, bif.mem_w_en, pend);
      end else if (pend) begin
        e = exp_q.pop_front();
        tests++;
        if ({bif.mem_w_addr, bif.mem_din} !== e) begin
          fails++; $display("FAIL load_write addr=%h din=%0d required addr=%h din=%0d",
                            bif.mem_w_addr, bif.mem_din, e[63:32], e[31:0]);
        end
      end
      if (pend && k == len) begin
        tests++;
        if (bif.s_ready !== 1'b0) begin fails++; $display("FAIL load_ready_drop s_ready=%b required 0", bif.s_ready); end
      end
      if (bif.done === 1'b1) begin
        ndone++; fin = 1'b1;
        tests++;
        if (bif.busy !== 1'b0) begin fails++; $display("FAIL load_busy_at_done busy=%b required 0", bif.busy); end
      end
      if (rst_after >= 0 && k == rst_after) begin
        rst = 1'b1; bif.s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; fin = 1'b1;
      end else if (k < len) begin
        bif.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        bif.s_data = src[k];
      end else bif.s_valid = 1'b0;
    end
    bif.s_valid = 1'b0;
    nbeats = k;
    if (!fin) begin tests++; fails++; $display("FAIL load_timeout beats=%0d required %0d", k, len); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bif.s_ready, bif.m_valid, bif.mem_w_en, bif.busy, bif.done} !== 5'b0) begin
      fails++; $display("FAIL reset_flags got %b required 00000",
                        {bif.s_ready, bif.m_valid, bif.mem_w_en, bif.busy, bif.done});
    end
    tests++;
    if ({bif.m_data, bif.mem_r_addr, bif.mem_w_addr, bif.mem_din, bif.checksum} !== 160'b0) begin
      fails++; $display("FAIL reset_data m_data=%h r_addr=%h w_addr=%h din=%h ck=%h required all 0",
                        bif.m_data, bif.mem_r_addr, bif.mem_w_addr, bif.mem_din, bif.checksum);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    int nb, nd;
    for (int i = 0; i < 10; i++) src[i] = words[i];
    do_load(32'h0, 10, 1'b0, -1, nb, nd);
    tests++;
    if (nb !== 10 || nd !== 1 || exp_q.size() !== 0) begin
      fails++; $display("FAIL load_counts beats=%0d done=%0d left=%0d required 10 1 0", nb, nd, exp_q.size());
    end
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (mem[i] !== words[i]) begin fails++; $display("FAIL load_mem[%0d] got %0d required %0d", i, mem[i], words[i]); end
    end
    tests++;
    if (bif.checksum !== exp_ck) begin fails++; $display("FAIL load_checksum got %0d required %0d", bif.checksum, exp_ck); end
  endtask

  task automatic test_dump();
    int nacc = 0, nd = 0, nwe = 0;
    bit fin = 1'b0, acc, stall;
    logic [31:0] held, e;
    dq.delete();
    for (int i = 0; i < 10; i++) dq.push_back(words[i]);
    bif.mode = 1'b1; bif.base_addr = 32'h0; bif.length = 16'd10; bif.m_ready = 1'b0; bif.start = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    tests++;
    if (bif.m_valid !== 1'b1) begin fails++; $display("FAIL dump_first m_valid=%b required 1", bif.m_valid); end
    for (int c = 0; c < 100 && !fin; c++) begin
      bif.m_ready = c % 2 == 0;
      acc = bif.m_valid && bif.m_ready;
      stall = bif.m_valid && !bif.m_ready;
      held = bif.m_data;
      if (acc) begin
        nacc++; tests++;
        if (dq.size() == 0) begin fails++; $display("FAIL dump_extra word %0d required none", bif.m_data); end
        else begin
          e = dq.pop_front();
          if (bif.m_data !== e) begin fails++; $display("FAIL dump_word got %0d required %0d", bif.m_data, e); end
        end
      end
      @(posedge clk); #1;
      if (stall) begin
        tests++;
        if (bif.m_valid !== 1'b1 || bif.m_data !== held) begin
          fails++; $display("FAIL dump_stall m_valid=%b m_data=%0d required 1 %0d", bif.m_valid, bif.m_data, held);
        end
      end
      if (bif.mem_w_en === 1'b1) nwe++;
      if (bif.done === 1'b1) begin nd++; fin = 1'b1; end
    end
    bif.m_ready = 1'b0;
    tests++;
    if (!fin || nacc !== 10 || dq.size() !== 0 || nd !== 1) begin
      fails++; $display("FAIL dump_counts fin=%b accepted=%0d left=%0d done=%0d required 1 10 0 1", fin, nacc, dq.size(), nd);
    end
    tests++;
    if (nwe !== 0) begin fails++; $display("FAIL dump_wen count=%0d required 0", nwe); end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bif.checksum !== exp_ck || bif.m_valid !== 1'b0 || bif.done !== 1'b0) begin
      fails++; $display("FAIL dump_after ck=%0d m_valid=%b done=%b required %0d 0 0", bif.checksum, bif.m_valid, bif.done, exp_ck);
    end
  endtask

  task automatic test_len0();
    for (int m = 0; m < 2; m++) begin
      int nbad = 0;
      bif.mode = 1'(m); bif.base_addr = 32'h0; bif.length = 16'd0; bif.start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
        @(posedge clk); #1;
        bif.start = 1'b0;
        if (bif.mem_w_en === 1'b1 || bif.m_valid === 1'b1 || bif.s_ready === 1'b1) nbad++;
        tests++;
        if (bif.done !== (c == 2)) begin
          fails++; $display("FAIL len0_done mode %0d cycle %0d: done=%b required %b", m, c, bif.done, c == 2);
        end
      end
      tests++;
      if (nbad !== 0) begin fails++; $display("FAIL len0_activity mode %0d: active cycles=%0d required 0", m, nbad); end
    end
  endtask

  task automatic test_wrap();
    int nb, nd;
    logic [15:0] a;
    for (int i = 0; i < 4; i++) src[i] = 32'hA000 + 32'(i);
    do_load(32'hFFFF_FFFE, 4, 1'b1, -1, nb, nd);
    tests++;
    if (nb !== 4 || nd !== 1 || exp_q.size() !== 0) begin
      fails++; $display("FAIL wrap_counts beats=%0d done=%0d left=%0d required 4 1 0", nb, nd, exp_q.size());
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      a = 16'hFFFE + 16'(i);
      tests++;
      if (mem[a] !== src[i]) begin fails++; $display("FAIL wrap_mem[%h] got %h required %h", a, mem[a], src[i]); end
    end
  endtask

  task automatic test_rst_mid();
    int nb, nd, nlate = 0;
    pre_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pre_a = 16'(i); pre_d = 32'hDEAD_0000 + 32'(i);
      @(posedge clk); #1;
    end
    pre_en = 1'b0;
    for (int i = 0; i < 8; i++) src[i] = 32'h5000 + 32'(i);
    do_load(32'h0, 8, 1'b1, 3, nb, nd);
    tests++;
    if (bif.busy !== 1'b0 || bif.s_ready !== 1'b0 || bif.mem_w_en !== 1'b0 || nb !== 3 || nd !== 0) begin
      fails++; $display("FAIL rst_mid_state busy=%b s_ready=%b wen=%b beats=%0d done=%0d required 0 0 0 3 0",
                        bif.busy, bif.s_ready, bif.mem_w_en, nb, nd);
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (bif.done === 1'b1 || bif.busy === 1'b1) nlate++;
    end
    tests++;
    if (nlate !== 0) begin fails++; $display("FAIL rst_mid_done late activity=%0d required 0", nlate); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (mem[i] !== (i < 3 ? src[i] : 32'hDEAD_0000 + 32'(i))) begin
        fails++; $display("FAIL rst_mid_mem[%0d] got %h required %h", i, mem[i], i < 3 ? src[i] : 32'hDEAD_0000 + 32'(i));
      end
    end
  endtask

  initial begin
    bif.start = 1'b0; bif.mode = 1'b0; bif.base_addr = '0; bif.length = '0;
    bif.s_valid = 1'b0; bif.s_data = '0; bif.m_ready = 1'b0;
    pre_en = 1'b0; pre_a = '0; pre_d = '0;
    test_reset();
    test_load();
    test_dump();
    test_len0();
    test_wrap();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
